// File: rtl/ft_recovery_if.sv
// Handshake bundle between the lockstep recovery controller and the core/shadow-file side.
// Valid/ready: a replay write transfers on a clock edge where replay_valid_o and replay_ready_i are both high.
interface ft_recovery_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
);
  logic                  error_i;
  logic                  halt_ack_i;
  logic                  replay_ready_i;
  logic                  enable_o;
  logic                  halt_o;
  logic                  replay_valid_o;
  logic [ADDR_WIDTH-1:0] replay_addr_o;
  logic                  pc_restore_o;
  logic                  resume_o;
  logic                  busy_o;
  logic                  fatal_o;
  logic [CNT_WIDTH-1:0]  recov_cnt_o;
  logic [2:0]            state_dbg;

  // Controller side.
  modport master (
    input  error_i, halt_ack_i, replay_ready_i,
    output enable_o, halt_o, replay_valid_o, replay_addr_o, pc_restore_o,
           resume_o, busy_o, fatal_o, recov_cnt_o, state_dbg
  );

  // Cores / comparator side.
  modport slave (
    output error_i, halt_ack_i, replay_ready_i,
    input  enable_o, halt_o, replay_valid_o, replay_addr_o, pc_restore_o,
           resume_o, busy_o, fatal_o, recov_cnt_o, state_dbg
  );
endinterface

// File: rtl/ft_recovery_ctrl.sv
// Lockstep error recovery sequencer: halt, drain, replay shadow GPRs, restore PC, resume.
// Optional macro REPLAY_SKIP_R0_EN: skip replaying x0 (hardwired zero).
module ft_recovery_ctrl #(
  parameter int ADDR_WIDTH   = 5,
  parameter int HALT_TIMEOUT = 64,
  parameter int CNT_WIDTH    = 8
) (
  input  logic          clk_i,
  input  logic          rst_n,
  ft_recovery_if.master bus
);

  localparam int TW = $clog2(HALT_TIMEOUT + 1);
  localparam logic [TW-1:0]         TO_LIMIT  = TW'(HALT_TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
`ifdef REPLAY_SKIP_R0_EN
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);
`else
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = '0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HALT   = 3'd1,
    S_REPLAY = 3'd2,
    S_PC     = 3'd3,
    S_RESUME = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t                state;
  logic [TW-1:0]         to_cnt;
  logic [TW-1:0]         to_next;
  logic                  enable_q;
  logic                  halt_q;
  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  pc_q;
  logic                  resume_q;
  logic                  busy_q;
  logic                  fatal_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  assign to_next = to_cnt + TW'(1);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      to_cnt   <= '0;
      enable_q <= 1'b1;
      halt_q   <= 1'b0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      pc_q     <= 1'b0;
      resume_q <= 1'b0;
      busy_q   <= 1'b0;
      fatal_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= 1'b0;
      resume_q <= 1'b0;
      case (state)
        S_IDLE: begin
          enable_q <= 1'b1;
          busy_q   <= 1'b0;
          halt_q   <= 1'b0;
          if (bus.error_i) begin
            state    <= S_HALT;
            halt_q   <= 1'b1;
            enable_q <= 1'b0;
            busy_q   <= 1'b1;
            to_cnt   <= '0;
            addr_q   <= FIRST_ADDR;
          end
        end
        S_HALT: begin
          to_cnt <= to_next;
          // Ack beats the timeout when both land on the same edge.
          if (bus.halt_ack_i) begin
            state   <= S_REPLAY;
            valid_q <= 1'b1;
            addr_q  <= FIRST_ADDR;
          end else if (to_next == TO_LIMIT) begin
            state   <= S_FAIL;
            fatal_q <= 1'b1;
          end
        end
        S_REPLAY: begin
          if (bus.replay_ready_i) begin
            if (addr_q == LAST_ADDR) begin
              state   <= S_PC;
              valid_q <= 1'b0;
              pc_q    <= 1'b1;
            end else begin
              addr_q <= addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        S_PC: begin
          state    <= S_RESUME;
          resume_q <= 1'b1;
          halt_q   <= 1'b0;
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
        S_RESUME: begin
          state    <= S_IDLE;
          enable_q <= 1'b1;
          busy_q   <= 1'b0;
        end
        S_FAIL: begin
          // Terminal until reset; outputs keep their FAIL values.
          halt_q   <= 1'b1;
          enable_q <= 1'b0;
          busy_q   <= 1'b1;
          fatal_q  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.enable_o       = enable_q;
  assign bus.halt_o         = halt_q;
  assign bus.replay_valid_o = valid_q;
  assign bus.replay_addr_o  = addr_q;
  assign bus.pc_restore_o   = pc_q;
  assign bus.resume_o       = resume_q;
  assign bus.busy_o         = busy_q;
  assign bus.fatal_o        = fatal_q;
  assign bus.recov_cnt_o    = cnt_q;
  assign bus.state_dbg      = state;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Bench for ft_recovery_ctrl: vector table, replay-address scoreboard, and hand-written corner sequences.
module tb_ft_recovery_ctrl;

  localparam int AW       = 5;
  localparam int NUM_REGS = 2 ** AW;
`ifdef REPLAY_SKIP_R0_EN
  localparam int FA = 1;
`else
  localparam int FA = 0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   rep_cycles;
  int   pc_pulses;
  int   exp_cnt;
  int   exp_cnt2;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_addr;

  ft_recovery_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(8)) bif ();
  ft_recovery_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(2)) bif2 ();

  ft_recovery_ctrl #(.ADDR_WIDTH(AW), .HALT_TIMEOUT(64), .CNT_WIDTH(8)) u_dut (
    .clk_i(clk), .rst_n(rst_n), .bus(bif.master)
  );
  ft_recovery_ctrl #(.ADDR_WIDTH(AW), .HALT_TIMEOUT(64), .CNT_WIDTH(2)) u_dut_sat (
    .clk_i(clk), .rst_n(rst_n), .bus(bif2.master)
  );

  assign bif2.error_i        = bif.error_i;
  assign bif2.halt_ack_i     = bif.halt_ack_i;
  assign bif2.replay_ready_i = bif.replay_ready_i;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each replay handshake must match the next queued address.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.replay_valid_o) rep_cycles++;
      if (bif.pc_restore_o) pc_pulses++;
      if (bif.replay_valid_o && bif.replay_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL replay_unexpected actual=%0d required=none", bif.replay_addr_o);
        end else begin
          mon_addr = exp_q.pop_front();
          chk("replay_addr", 32'(bif.replay_addr_o), 32'(mon_addr));
        end
      end
    end
  end

  task automatic push_expected();
    exp_q.delete();
    for (int a = FA; a < NUM_REGS; a++) exp_q.push_back(AW'(a));
    rep_cycles = 0;
    pc_pulses  = 0;
  endtask

  task automatic model_count();
    exp_cnt  = (exp_cnt == 255) ? 255 : exp_cnt + 1;
    exp_cnt2 = (exp_cnt2 == 3) ? 3 : exp_cnt2 + 1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_enable"}, 32'(bif.enable_o), 1);
    chk({tag, "_halt"}, 32'(bif.halt_o), 0);
    chk({tag, "_valid"}, 32'(bif.replay_valid_o), 0);
    chk({tag, "_addr"}, 32'(bif.replay_addr_o), 0);
    chk({tag, "_pc"}, 32'(bif.pc_restore_o), 0);
    chk({tag, "_resume"}, 32'(bif.resume_o), 0);
    chk({tag, "_busy"}, 32'(bif.busy_o), 0);
    chk({tag, "_fatal"}, 32'(bif.fatal_o), 0);
    chk({tag, "_cnt"}, 32'(bif.recov_cnt_o), 0);
    chk({tag, "_cnt_sat"}, 32'(bif2.recov_cnt_o), 0);
  endtask

  // Wait for resume_o with ack/ready as currently driven; returns edges seen.
  task automatic finish_recovery(input string tag, inout int edges);
    while (!bif.resume_o && edges < 300) begin
      tick();
      edges++;
    end
    if (!bif.resume_o) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_resume required=resume", tag);
    end
    chk({tag, "_halt_in_resume"}, 32'(bif.halt_o), 0);
    model_count();
    chk({tag, "_recov_cnt"}, 32'(bif.recov_cnt_o), 32'(exp_cnt));
    chk({tag, "_recov_cnt_sat"}, 32'(bif2.recov_cnt_o), 32'(exp_cnt2));
    chk({tag, "_pc_pulses"}, 32'(pc_pulses), 1);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
    bif.error_i = 1'b0;
    tick();
    chk({tag, "_enable_after"}, 32'(bif.enable_o), 1);
    chk({tag, "_busy_after"}, 32'(bif.busy_o), 0);
  endtask

  task automatic do_recovery(input string tag, output int edges);
    push_expected();
    bif.error_i        = 1'b1;
    bif.halt_ack_i     = 1'b1;
    bif.replay_ready_i = 1'b1;
    tick();
    edges = 1;
    bif.error_i = 1'b0;
    chk({tag, "_halt_rise"}, 32'(bif.halt_o), 1);
    chk({tag, "_enable_low"}, 32'(bif.enable_o), 0);
    finish_recovery(tag, edges);
  endtask

  typedef struct {
    logic          err;
    logic          ack;
    logic          rdy;
    logic          halt;
    logic          en;
    logic          busy;
    logic          valid;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t vecs[7];
  int   edges;
  int   k;
  int   hc;

  initial begin
    checks   = 0;
    errors   = 0;
    exp_cnt  = 0;
    exp_cnt2 = 0;
    rep_cycles = 0;
    pc_pulses  = 0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, AW'(FA)};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, AW'(FA)};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, AW'(FA)};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, AW'(FA)};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, AW'(FA + 1)};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, AW'(FA + 2)};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, AW'(FA + 2)};

    rst_n              = 1'b0;
    bif.error_i        = 1'b0;
    bif.halt_ack_i     = 1'b0;
    bif.replay_ready_i = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_reset_vals("reset");
    chk("reset_state", 32'(bif.state_dbg), 0);

    // Nominal recovery, ack and ready tied high.
    do_recovery("nominal", edges);
    chk("nominal_latency", 32'(edges), 32'(NUM_REGS + 3 - FA));
    chk("nominal_replay_cycles", 32'(rep_cycles), 32'(NUM_REGS - FA));

    // Table: delayed ack, error during REPLAY, ack drop, light backpressure.
    push_expected();
    for (int i = 0; i < 7; i++) begin
      bif.error_i        = vecs[i].err;
      bif.halt_ack_i     = vecs[i].ack;
      bif.replay_ready_i = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d_halt", i), 32'(bif.halt_o), 32'(vecs[i].halt));
      chk($sformatf("vec%0d_enable", i), 32'(bif.enable_o), 32'(vecs[i].en));
      chk($sformatf("vec%0d_busy", i), 32'(bif.busy_o), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_valid", i), 32'(bif.replay_valid_o), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_addr", i), 32'(bif.replay_addr_o), 32'(vecs[i].addr));
    end
    bif.error_i        = 1'b0;
    bif.replay_ready_i = 1'b1;
    edges = 0;
    finish_recovery("table", edges);

    // Backpressure: ready low on every other REPLAY cycle.
    push_expected();
    bif.error_i        = 1'b1;
    bif.halt_ack_i     = 1'b1;
    bif.replay_ready_i = 1'b0;
    tick();
    bif.error_i = 1'b0;
    k     = 0;
    edges = 1;
    while (!bif.resume_o && edges < 300) begin
      if (bif.replay_valid_o) begin
        bif.replay_ready_i = (k % 2 == 1);
        k++;
      end else begin
        bif.replay_ready_i = 1'b0;
      end
      tick();
      edges++;
    end
    finish_recovery("backpressure", edges);
    chk("backpressure_replay_cycles", 32'(rep_cycles), 32'(2 * (NUM_REGS - FA)));

    // Asynchronous reset in the middle of REPLAY.
    push_expected();
    bif.error_i        = 1'b1;
    bif.halt_ack_i     = 1'b1;
    bif.replay_ready_i = 1'b1;
    tick();
    bif.error_i = 1'b0;
    edges = 0;
    while (!(bif.replay_valid_o && bif.replay_addr_o == AW'(10)) && edges < 50) begin
      tick();
      edges++;
    end
    chk("midreset_reached_addr10", 32'(bif.replay_addr_o), 10);
    bif.replay_ready_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    exp_q.delete();
    exp_cnt  = 0;
    exp_cnt2 = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("midreset_idle_state", 32'(bif.state_dbg), 0);

    // Halt timeout into FAIL.
    bif.error_i        = 1'b1;
    bif.halt_ack_i     = 1'b0;
    bif.replay_ready_i = 1'b0;
    tick();
    bif.error_i = 1'b0;
    hc = 0;
    while (!bif.fatal_o && hc < 200) begin
      if (bif.busy_o) hc++;
      tick();
    end
    chk("timeout_halt_cycles", 32'(hc), 64);
    chk("fail_fatal", 32'(bif.fatal_o), 1);
    chk("fail_halt", 32'(bif.halt_o), 1);
    chk("fail_enable", 32'(bif.enable_o), 0);
    chk("fail_busy", 32'(bif.busy_o), 1);
    bif.error_i        = 1'b1;
    bif.halt_ack_i     = 1'b1;
    bif.replay_ready_i = 1'b1;
    repeat (5) tick();
    chk("fail_sticky_fatal", 32'(bif.fatal_o), 1);
    chk("fail_sticky_valid", 32'(bif.replay_valid_o), 0);
    chk("fail_sticky_resume", 32'(bif.resume_o), 0);
    chk("fail_sticky_cnt", 32'(bif.recov_cnt_o), 0);
    bif.error_i = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_vals("fail_cleared");

    // Back-to-back recoveries; the narrow counter saturates at 3.
    for (int r = 0; r < 5; r++) begin
      do_recovery($sformatf("b2b%0d", r), edges);
      chk($sformatf("b2b%0d_latency", r), 32'(edges), 32'(NUM_REGS + 3 - FA));
    end
    chk("sat_final", 32'(bif2.recov_cnt_o), 3);
    chk("wide_final", 32'(bif.recov_cnt_o), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
